// File: rtl/fib_pkg.sv
// fib_pkg: shared widths, FSM states and instruction layout for the Fibonacci calculator
package fib_pkg;
  localparam int INSTR_W = 7;
  localparam int OPC_W = 3;
  localparam int REG_W = 2;
  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] op1;
    logic [REG_W-1:0] op2;
  } instr_t;
endpackage

// File: rtl/fib_prog_mem.sv
// fib_prog_mem: program store with synchronous write and asynchronous read
module fib_prog_mem
  import fib_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  instr_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output instr_t        rdata_o
);
  instr_t mem [DEPTH];
  always_ff @(posedge clk) if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/fib_instr_seq.sv
// fib_instr_seq: issues prologue, n_iter loop-body passes and epilogue from program memory
module fib_instr_seq
  import fib_pkg::*;
#(
  parameter int PROG_DEPTH = 8,
  parameter int LOOP_START = 2,
  parameter int LOOP_END = 5,
  localparam int AW = PROG_DEPTH > 1 ? $clog2(PROG_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         n_iter,
  input  logic               stall,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   op1,
  output logic [REG_W-1:0]   op2,
  output logic               instr_valid,
  output logic [AW-1:0]      pc,
  output logic [7:0]         iter_cnt,
  output logic               busy,
  output logic               done
);
  localparam logic [AW:0] EXIT = (AW+1)'(LOOP_END + 1);
  state_e state_q;
  instr_t instr_q, instr_d, rd;
  logic [AW-1:0] pc_q, raddr;
  logic [7:0] n_q, iter_q, iter_d;
  logic valid_q, busy_q, done_q, end_run;
  logic [AW:0] pc_d;
  fib_prog_mem #(.DEPTH(PROG_DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we_i(state_q == S_IDLE && prog_we),
    .waddr_i(prog_addr),
    .wdata_i(instr_t'(prog_data)),
    .raddr_i(raddr),
    .rdata_o(rd)
  );
  // pc_d is one bit wider so running past the last word is visible as the end of the run
  always_comb begin
    iter_d = iter_q + 8'd1;
    pc_d = (pc_q == AW'(LOOP_START - 1) && n_q == 8'd0) ? EXIT :
           (pc_q == AW'(LOOP_END)) ? (iter_d < n_q ? (AW+1)'(LOOP_START) : EXIT) :
           {1'b0, pc_q} + 1'b1;
    end_run = pc_d >= (AW+1)'(PROG_DEPTH);
    raddr = state_q == S_IDLE ? '0 : pc_d[AW-1:0];
    instr_d = (state_q == S_IDLE && prog_we && prog_addr == '0) ? instr_t'(prog_data) : rd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q <= '0;
      n_q <= '0;
      iter_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      done_q <= 1'b0;
      if (start) begin
        n_q <= n_iter;
        iter_q <= '0;
        instr_q <= instr_d;
        pc_q <= '0;
        valid_q <= 1'b1;
        busy_q <= 1'b1;
        state_q <= S_RUN;
      end
    end else if (!stall) begin
      if (pc_q == AW'(LOOP_END)) iter_q <= iter_d;
      if (end_run) begin
        valid_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
        state_q <= S_IDLE;
      end else begin
        pc_q <= pc_d[AW-1:0];
        instr_q <= instr_d;
      end
    end
  end
  assign opcode = instr_q.opcode;
  assign op1 = instr_q.op1;
  assign op2 = instr_q.op2;
  assign instr_valid = valid_q;
  assign pc = pc_q;
  assign iter_cnt = iter_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
